// File: rtl/coin_pkg.sv
// Coin values and dispenser FSM encodings, shared with the coin acceptor.
package coin_pkg;
  localparam logic [7:0] COIN5_VAL  = 8'd5;
  localparam logic [7:0] COIN10_VAL = 8'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_t;
endpackage

// File: rtl/pulse_spacer.sv
// Loadable down-counter that times the quiet interval between coin pulses.
// o_tc is high while the count sits at zero.
module pulse_spacer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;

  // Load on request, otherwise count down while enabled and stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/change_dispenser.sv
// Greedy refund dispenser: ten-unit coins first, then five-unit coins, with a
// fixed quiet gap after every pulse. Whatever cannot be paid is reported as
// shortfall on the done pulse. All outputs come straight from flops.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int GAP          = 3,
  parameter int STOCK10_INIT = 8,
  parameter int STOCK5_INIT  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic [7:0] i_req_amount,
  output logic       o_req_ready,
  input  logic       i_refill,
  output logic       o_coin10,
  output logic       o_coin5,
  output logic       o_done,
  output logic [7:0] o_shortfall,
  output logic [7:0] o_stock10,
  output logic [7:0] o_stock5
);
  localparam logic [7:0] S10_INIT = 8'(STOCK10_INIT);
  localparam logic [7:0] S5_INIT  = 8'(STOCK5_INIT);
  // Spacer runs GAP-1 .. 0, giving GAP cycles in the GAP state.
  localparam logic [3:0] GAP_M1   = 4'(GAP - 1);

  disp_state_t r_state, w_state_nxt;
  logic [7:0]  r_rem, w_rem_nxt;
  logic [7:0]  r_s10, w_s10_nxt;
  logic [7:0]  r_s5, w_s5_nxt;
  logic        r_coin10, w_coin10_nxt;
  logic        r_coin5, w_coin5_nxt;
  logic        r_done, w_done_nxt;
  logic [7:0]  r_sf, w_sf_nxt;
  logic        r_ready, w_ready_nxt;
  logic        w_load, w_tc;

  pulse_spacer #(.W(4)) u_spacer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (GAP_M1),
    .i_en       (r_state == ST_GAP),
    .o_tc       (w_tc)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_s10_nxt    = r_s10;
    w_s5_nxt     = r_s5;
    w_coin10_nxt = 1'b0;
    w_coin5_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    w_sf_nxt     = 8'd0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Refill lands before the decision so a same-cycle request sees it.
        if (i_refill) begin
          w_s10_nxt = S10_INIT;
          w_s5_nxt  = S5_INIT;
        end
        if (i_req_valid) begin
          w_rem_nxt   = i_req_amount;
          w_state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (r_rem >= COIN10_VAL && r_s10 != 8'd0) begin
          w_rem_nxt    = r_rem - COIN10_VAL;
          w_s10_nxt    = r_s10 - 8'd1;
          w_coin10_nxt = 1'b1;
          w_state_nxt  = ST_PULSE;
        end else if (r_rem >= COIN5_VAL && r_s5 != 8'd0) begin
          w_rem_nxt    = r_rem - COIN5_VAL;
          w_s5_nxt     = r_s5 - 8'd1;
          w_coin5_nxt  = 1'b1;
          w_state_nxt  = ST_PULSE;
        end else begin
          w_done_nxt   = 1'b1;
          w_sf_nxt     = r_rem;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_PULSE: begin
        w_load      = 1'b1;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_tc) w_state_nxt = ST_DECIDE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // State and output registers; reset overrides refill and requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_rem    <= 8'd0;
      r_s10    <= S10_INIT;
      r_s5     <= S5_INIT;
      r_coin10 <= 1'b0;
      r_coin5  <= 1'b0;
      r_done   <= 1'b0;
      r_sf     <= 8'd0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_s10    <= w_s10_nxt;
      r_s5     <= w_s5_nxt;
      r_coin10 <= w_coin10_nxt;
      r_coin5  <= w_coin5_nxt;
      r_done   <= w_done_nxt;
      r_sf     <= w_sf_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign o_req_ready = r_ready;
  assign o_coin10    = r_coin10;
  assign o_coin5     = r_coin5;
  assign o_done      = r_done;
  assign o_shortfall = r_sf;
  assign o_stock10   = r_s10;
  assign o_stock5    = r_s5;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three instances with different hopper and gap
// settings share one stimulus stream. A per-instance model turns each accepted
// request into an expected cycle-by-cycle output timeline using plain coin
// arithmetic; a negedge process compares every output every cycle, and
// directed literal checks pin the model to hand-computed results.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       refill = 1'b0;
  logic [7:0] req_amount = 8'd0;

  always #5 clk = ~clk;

  logic       rdy[3], c10[3], c5[3], dn[3];
  logic [7:0] sf[3], s10[3], s5[3];

  localparam int S10I[3] = '{8, 0, 1};
  localparam int S5I[3]  = '{8, 8, 1};
  localparam int GAPV[3] = '{3, 3, 1};

  change_dispenser #(.GAP(3), .STOCK10_INIT(8), .STOCK5_INIT(8)) u0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_amount(req_amount),
    .o_req_ready(rdy[0]), .i_refill(refill), .o_coin10(c10[0]), .o_coin5(c5[0]),
    .o_done(dn[0]), .o_shortfall(sf[0]), .o_stock10(s10[0]), .o_stock5(s5[0]));
  change_dispenser #(.GAP(3), .STOCK10_INIT(0), .STOCK5_INIT(8)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_amount(req_amount),
    .o_req_ready(rdy[1]), .i_refill(refill), .o_coin10(c10[1]), .o_coin5(c5[1]),
    .o_done(dn[1]), .o_shortfall(sf[1]), .o_stock10(s10[1]), .o_stock5(s5[1]));
  change_dispenser #(.GAP(1), .STOCK10_INIT(1), .STOCK5_INIT(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_amount(req_amount),
    .o_req_ready(rdy[2]), .i_refill(refill), .o_coin10(c10[2]), .o_coin5(c5[2]),
    .o_done(dn[2]), .o_shortfall(sf[2]), .o_stock10(s10[2]), .o_stock5(s5[2]));

  typedef struct {
    int rdy, c10, c5, dn, sf, s10, s5;
  } exp_t;

  exp_t q[3][$];
  int   ms10[3], ms5[3];
  int   cyc = 0;
  bit   started = 1'b0;
  int   npass = 0, ntot = 0;
  // Observations: cumulative pulse counts, cycle stamp of latest pulse.
  int   n10[3], n5[3], ndn[3], t10[3], t5[3], tdn[3], sfd[3];
  int   tacc = 0;

  function automatic exp_t mk(int r, int a, int b, int d, int s, int x, int y);
    exp_t e;
    e.rdy = r; e.c10 = a; e.c5 = b; e.dn = d; e.sf = s; e.s10 = x; e.s5 = y;
    return e;
  endfunction

  function automatic void chk(string nm, int d, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s dut%0d cyc=%0d act=%0d exp=%0d", nm, d, cyc, act, exp);
  endfunction

  // Greedy payout by arithmetic, then laid out as a timeline:
  // decide, then per coin (pulse, GAP quiet cycles, decide), then done.
  function automatic void build(int d, int amt);
    int rem, k10, k5;
    rem = amt;
    k10 = (rem / 10 < ms10[d]) ? rem / 10 : ms10[d];
    rem -= 10 * k10;
    k5  = (rem / 5 < ms5[d]) ? rem / 5 : ms5[d];
    rem -= 5 * k5;
    q[d].push_back(mk(0, 0, 0, 0, 0, ms10[d], ms5[d]));
    for (int k = 0; k < k10 + k5; k++) begin
      if (k < k10) begin
        ms10[d]--;
        q[d].push_back(mk(0, 1, 0, 0, 0, ms10[d], ms5[d]));
      end else begin
        ms5[d]--;
        q[d].push_back(mk(0, 0, 1, 0, 0, ms10[d], ms5[d]));
      end
      for (int g = 0; g < GAPV[d] + 1; g++)
        q[d].push_back(mk(0, 0, 0, 0, 0, ms10[d], ms5[d]));
    end
    q[d].push_back(mk(0, 0, 0, 1, rem, ms10[d], ms5[d]));
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        q[d].delete();
        ms10[d] = S10I[d];
        ms5[d]  = S5I[d];
      end else if (q[d].size() != 0) begin
        q[d].delete(0);
      end else begin
        if (refill) begin
          ms10[d] = S10I[d];
          ms5[d]  = S5I[d];
        end
        if (req_valid) build(d, int'(req_amount));
      end
    end
    if (rst) started = 1'b1;
  end

  // Compare and observe on each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        if (q[d].size() != 0) e = q[d][0];
        else e = mk(1, 0, 0, 0, 0, ms10[d], ms5[d]);
        chk("req_ready", d, int'(rdy[d]), e.rdy);
        chk("coin10",    d, int'(c10[d]), e.c10);
        chk("coin5",     d, int'(c5[d]),  e.c5);
        chk("done",      d, int'(dn[d]),  e.dn);
        chk("shortfall", d, int'(sf[d]),  e.sf);
        chk("stock10",   d, int'(s10[d]), e.s10);
        chk("stock5",    d, int'(s5[d]),  e.s5);
        if (c10[d]) begin n10[d]++; t10[d] = cyc; end
        if (c5[d])  begin n5[d]++;  t5[d]  = cyc; end
        if (dn[d])  begin ndn[d]++; tdn[d] = cyc; sfd[d] = int'(sf[d]); end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (rdy[0] && rdy[1] && rdy[2]) return;
      @(negedge clk);
    end
    chk("idle_timeout", 0, 0, 1);
  endtask

  task automatic send(int amt, bit rf);
    wait_idle();
    req_valid  = 1'b1;
    req_amount = 8'(amt);
    refill     = rf;
    tacc       = cyc;
    @(negedge clk);
    req_valid  = 1'b0;
    refill     = 1'b0;
  endtask

  initial begin
    int b10, b5, bd, b10b, b5b;
    for (int d = 0; d < 3; d++) begin
      n10[d] = 0; n5[d] = 0; ndn[d] = 0; t10[d] = 0; t5[d] = 0; tdn[d] = 0; sfd[d] = 0;
    end

    // Reset state and the 15-unit latency example.
    do_reset();
    tick(2);
    chk("rst_stock10", 0, int'(s10[0]), 8);
    chk("rst_stock5",  2, int'(s5[2]), 1);
    chk("rst_ready",   1, int'(rdy[1]), 1);
    send(15, 1'b0);
    wait_idle();
    chk("lat_coin10", 0, t10[0] - tacc, 2);
    chk("lat_coin5",  0, t5[0] - tacc, 7);
    chk("lat_done",   0, tdn[0] - tacc, 12);
    chk("sf15",       0, sfd[0], 0);
    chk("stk10_15",   0, int'(s10[0]), 7);
    chk("stk5_15",    0, int'(s5[0]), 7);

    // 7 units: one five, two left over.
    do_reset();
    b5 = n5[0]; b10 = n10[0];
    send(7, 1'b0);
    wait_idle();
    chk("n5_7",  0, n5[0] - b5, 1);
    chk("n10_7", 0, n10[0] - b10, 0);
    chk("sf7",   0, sfd[0], 2);

    // 20 units with no ten-unit coins: four fives, GAP+2 apart.
    do_reset();
    b5 = n5[1];
    send(20, 1'b0);
    wait_idle();
    chk("n5_20",    1, n5[1] - b5, 4);
    chk("last5_20", 1, t5[1] - tacc, 17);
    chk("sf20",     1, sfd[1], 0);
    chk("stk5_20",  1, int'(s5[1]), 4);

    // 40 units from a one-and-one hopper: exhaustion shortfall.
    do_reset();
    b10 = n10[2]; b5 = n5[2];
    send(40, 1'b0);
    wait_idle();
    chk("n10_40",   2, n10[2] - b10, 1);
    chk("n5_40",    2, n5[2] - b5, 1);
    chk("sf40",     2, sfd[2], 25);
    chk("stk10_40", 2, int'(s10[2]), 0);
    chk("stk5_40",  2, int'(s5[2]), 0);

    // Reset during the gap after the first coin of a 30-unit refund.
    do_reset();
    b10 = n10[0]; b5 = n5[0]; bd = ndn[0];
    send(30, 1'b0);
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready",   0, int'(rdy[0]), 1);
    chk("abort_stock10", 0, int'(s10[0]), 8);
    tick(20);
    chk("abort_n10",  0, n10[0] - b10, 1);
    chk("abort_n5",   0, n5[0] - b5, 0);
    chk("abort_done", 0, ndn[0] - bd, 0);

    // Refill together with a request after the ten-unit hopper ran dry.
    do_reset();
    send(10, 1'b0);
    wait_idle();
    chk("dry_stock10", 2, int'(s10[2]), 0);
    b10b = n10[2]; b5b = n5[2];
    send(10, 1'b1);
    wait_idle();
    chk("refill_n10",     2, n10[2] - b10b, 1);
    chk("refill_n5",      2, n5[2] - b5b, 0);
    chk("refill_stock10", 2, int'(s10[2]), 0);
    chk("refill_stk10_0", 0, int'(s10[0]), 7);

    // Zero amount: straight to done.
    bd = ndn[0]; b10 = n10[0]; b5 = n5[0];
    send(0, 1'b0);
    wait_idle();
    chk("zero_done", 0, tdn[0] - tacc, 2);
    chk("zero_sf",   0, sfd[0], 0);
    chk("zero_coins", 0, (n10[0] - b10) + (n5[0] - b5), 0);

    // Requests and refill while busy are ignored (model tracks all three).
    send(23, 1'b0);
    tick(3);
    req_valid = 1'b1; refill = 1'b1; req_amount = 8'd50;
    tick(4);
    req_valid = 1'b0; refill = 1'b0;
    wait_idle();
    chk("busy_sf23", 0, sfd[0], 3);

    // A few random refunds, occasionally with refill.
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    tick(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
